interleaved_sync_fifo_nbank: RTL and testbench
==============================================

// Module: interleaved_sync_fifo_nbank
// PURPOSE
//  1-write/1-read-per-cycle synchronous FIFO built from NUM_BANKS sync_2t_fifo banks (BRAM-friendly, 2-cycle-per-op).
//  Words are striped round-robin across banks on write and gathered round-robin on read, so strict input order holds.
//  Adds almost-full/almost-empty flags and a sticky overflow/underflow error. Drop-in stream buffer for valid/ready pipelines.
// PARAMETERS
//  DATA_WIDTH  8    data bits per word
//  FIFO_DEPTH  256  total capacity in words; multiple of NUM_BANKS, FIFO_DEPTH/NUM_BANKS >= 2
//  NUM_BANKS   2    number of interleaved sync_2t_fifo banks; power of 2, >= 2
//  AF_THRESH   FIFO_DEPTH-2  almost_full asserts when count >= AF_THRESH (1..FIFO_DEPTH)
//  AE_THRESH   1    almost_empty asserts when count <= AE_THRESH (0..FIFO_DEPTH-1)
// PORTS
//  clk           in   1                      clock, all logic on rising edge
//  rstn          in   1                      asynchronous, active-low reset
//  clear         in   1                      synchronous flush, active high
//  in_data       in   DATA_WIDTH             write data
//  in_valid      in   1                      write request
//  in_ready      out  1                      write accepted when in_valid & in_ready
//  out_data      out  DATA_WIDTH             read data, valid when out_valid
//  out_valid     out  1                      head word available
//  out_ready     in   1                      read accepted when out_valid & out_ready
//  count         out  $clog2(FIFO_DEPTH)+1   words accepted and not yet read
//  almost_full   out  1                      count >= AF_THRESH
//  almost_empty  out  1                      count <= AE_THRESH
//  err           out  1                      sticky: in_valid while !in_ready at count==FIFO_DEPTH, or out_ready while !out_valid at count==0? no: out_ready never errors; see BEHAVIOUR
// BEHAVIOUR
//  Reset (rstn low, async) and clear (sync, next edge): count=0, all staging/prefetch regs invalid, wr_sel=rd_sel=0, err=0.
//   Outputs after reset: in_ready=1, out_valid=0, out_data=0, almost_empty=1, almost_full=0, err=0.
//   During a clear cycle in_ready=0 and out_valid is ignored; no transfer in that cycle counts.
//  Structure: per bank b: input staging reg (data+valid), sync_2t_fifo depth FIFO_DEPTH/NUM_BANKS, output prefetch reg (data+valid).
//  Write: k-th accepted word (k from 0 since reset/clear) goes to bank k mod NUM_BANKS; wr_sel advances by 1 mod NUM_BANKS per accept.
//   in_ready = (count < FIFO_DEPTH) & !staging_valid[wr_sel]. Staging reg drains into its bank when bank in_ready.
//  Read: out_data/out_valid = prefetch reg of bank rd_sel; rd_sel advances by 1 mod NUM_BANKS per accepted read.
//   Prefetch reg refills from its bank whenever empty and bank out_valid (same-cycle refill after consume not required).
//  count: +1 on write only, -1 on read only, unchanged on both or neither; never wraps (0..FIFO_DEPTH).
//  Flags almost_full/almost_empty are combinational from registered count.
//  err: sets on any cycle with in_valid & !in_ready & count==FIFO_DEPTH (write to full); cleared only by reset/clear.
//  Throughput: once primed, sustained 1 write and 1 read per cycle with both sides continuously valid/ready; no bubbles.
//  Latency: word accepted into empty FIFO shows out_valid within 5 cycles (staging 1, bank write/read 2-3, prefetch 1).
//  Full: count==FIFO_DEPTH -> in_ready=0; pending in_valid held by upstream, no data lost or duplicated.
//  Empty: out_valid=0; out_ready ignored, count stays 0.
//  Simultaneous read+write at count==FIFO_DEPTH: write refused (in_ready already 0), read proceeds, count->FIFO_DEPTH-1.
//  Pointer wrap: wr_sel/rd_sel and bank-internal pointers wrap silently; ordering preserved across wrap.
//  Reset or clear mid-transfer: all in-flight words discarded; first word written after is first word read.
// TESTING
//  1 Reset: release rstn -> count=0, in_ready=1, out_valid=0, almost_empty=1, almost_full=0, err=0.
//  2 Stream: NUM_BANKS=4, DEPTH=16, write 0..199 with out_ready=1 -> reads 0..199 in order, zero bubbles after first output.
//  3 Fill: out_ready=0, write 0..16 -> 16 accepted, count=16, in_ready=0, almost_full=1 from count=14, err=1; drain reads 0..15.
//  4 Simultaneous: at count=8 hold in/out handshakes 20 cycles -> count stays 8, data order intact.
//  5 Clear: count=7, pulse clear -> next cycle count=0, out_valid=0; write 0xA5 -> first read 0xA5.
//  6 Random: random in_valid/out_ready, NUM_BANKS in {2,4,8}, async rstn mid-run -> scoreboard match, count==model.
```

Note: the `err` port line ends in an unresolved "? no:" clause. Its meaning is as defined in BEHAVIOUR: the flag is sticky and sets only on a write attempted while the FIFO is full. A read attempted while the FIFO is empty never sets it.

Source files
------------

// File: rtl/interleaved_sync_fifo_nbank_if.sv
// Stream interface for interleaved_sync_fifo_nbank.
// Groups the write handshake, the read handshake and the status outputs.
//   master : upstream/downstream user (drives in_data/in_valid/out_ready)
//   slave  : the FIFO itself
// Signals:
//   in_data/in_valid/in_ready     write side, transfer on in_valid & in_ready
//   out_data/out_valid/out_ready  read side, transfer on out_valid & out_ready
//   count                         words held, 0..FIFO_DEPTH
//   almost_full/almost_empty/err  status flags
interface interleaved_sync_fifo_nbank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  err;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, almost_full, almost_empty, err
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, almost_full, almost_empty, err
  );
endinterface

// File: rtl/interleaved_sync_fifo_nbank.sv
// Interleaved synchronous FIFO: one write and one read per cycle built from
// NUM_BANKS slow (one op per two cycles per side) RAM-style banks.
// Accepted words are striped round-robin across banks through per-bank
// staging registers and gathered round-robin through per-bank prefetch
// registers, so output order equals input order.
// Ports:
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset
//   clear  synchronous flush, active high
//   bus    interleaved_sync_fifo_nbank_if.slave (handshakes, count, flags)

// Single bank: RAM array with registered read, at most one write every
// other cycle and one fetch every other cycle.
//   wr_data/wr_valid/wr_ready  write port
//   rd_data/rd_valid/rd_ready  output register, popped on rd_valid & rd_ready
module sync_2t_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rd_q;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_busy_q, wr_busy_d;
  logic          rd_busy_q, rd_busy_d;
  logic          dv_q, dv_d;
  logic          wr_fire, fetch;

  // cnt_q counts words in the array only; the output register is separate.
  assign wr_ready = !clear && !wr_busy_q && (cnt_q != FULL);
  assign wr_fire  = wr_valid && wr_ready;
  // Fetch when the output register is free or being popped this cycle.
  assign fetch    = !clear && !rd_busy_q && (cnt_q != '0) && (!dv_q || rd_ready);
  assign rd_data  = mem_rd_q;
  assign rd_valid = dv_q;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    wr_busy_d = wr_fire;
    rd_busy_d = fetch;
    dv_d      = dv_q;
    if (wr_fire) wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
    if (fetch)   rp_d = (rp_q == LAST) ? '0 : rp_q + 1'b1;
    case ({wr_fire, fetch})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (fetch)         dv_d = 1'b1;
    else if (rd_ready) dv_d = 1'b0;
    if (clear) begin
      wp_d      = '0;
      rp_d      = '0;
      cnt_d     = '0;
      wr_busy_d = 1'b0;
      rd_busy_d = 1'b0;
      dv_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      wr_busy_q <= 1'b0;
      rd_busy_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      wr_busy_q <= wr_busy_d;
      rd_busy_q <= rd_busy_d;
      dv_q      <= dv_d;
    end
  end

  // Array and its read register have no reset so they map onto block RAM;
  // rd_data is only meaningful while dv_q is set.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wp_q] <= wr_data;
    if (fetch)   mem_rd_q  <= mem[rp_q];
  end
endmodule

module interleaved_sync_fifo_nbank #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int NUM_BANKS  = 2,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clear,
  interleaved_sync_fifo_nbank_if.slave  bus
);
  localparam int BANK_DEPTH = FIFO_DEPTH / NUM_BANKS;
  localparam int SW         = $clog2(NUM_BANKS);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_T = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] stg_data_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0] stg_data_d [NUM_BANKS];
  logic [NUM_BANKS-1:0]  stg_v_q, stg_v_d;
  logic [DATA_WIDTH-1:0] pf_data_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0] pf_data_d [NUM_BANKS];
  logic [NUM_BANKS-1:0]  pf_v_q, pf_v_d;
  logic [SW-1:0]         wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;

  logic [NUM_BANKS-1:0]  bk_wr_ready, bk_rd_valid, bk_rd_ready;
  logic [DATA_WIDTH-1:0] bk_rd_data [NUM_BANKS];

  logic in_ready_int, out_valid_int, wr_fire, rd_fire;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sync_2t_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (clear),
      .wr_data  (stg_data_q[b]),
      .wr_valid (stg_v_q[b]),
      .wr_ready (bk_wr_ready[b]),
      .rd_data  (bk_rd_data[b]),
      .rd_valid (bk_rd_valid[b]),
      .rd_ready (bk_rd_ready[b])
    );
    // Bank output is pulled into the prefetch register whenever it is empty.
    assign bk_rd_ready[b] = !pf_v_q[b];
  end

  // count bounds occupancy, so a bank can never hold more than its depth;
  // the staging check only covers a bank still busy with its previous word.
  assign in_ready_int  = !clear && (count_q < FULL) && !stg_v_q[wr_sel_q];
  assign out_valid_int = pf_v_q[rd_sel_q];
  assign wr_fire       = bus.in_valid && in_ready_int;
  assign rd_fire       = out_valid_int && bus.out_ready && !clear;

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = out_valid_int;
  assign bus.out_data     = pf_data_q[rd_sel_q];
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_T);
  assign bus.almost_empty = (count_q <= AE_T);
  assign bus.err          = err_q;

  always_comb begin
    stg_data_d = stg_data_q;
    stg_v_d    = stg_v_q;
    pf_data_d  = pf_data_q;
    pf_v_d     = pf_v_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    count_d    = count_q;
    err_d      = err_q;

    for (int b = 0; b < NUM_BANKS; b++) begin
      if (stg_v_q[b] && bk_wr_ready[b]) stg_v_d[b] = 1'b0;
      // Load only happens when the staging reg is empty, so it never
      // collides with the drain above.
      if (wr_fire && (wr_sel_q == SW'(b))) begin
        stg_v_d[b]    = 1'b1;
        stg_data_d[b] = bus.in_data;
      end
      if (rd_fire && (rd_sel_q == SW'(b))) pf_v_d[b] = 1'b0;
      if (!pf_v_q[b] && bk_rd_valid[b]) begin
        pf_v_d[b]    = 1'b1;
        pf_data_d[b] = bk_rd_data[b];
      end
    end

    if (wr_fire) wr_sel_d = wr_sel_q + 1'b1;
    if (rd_fire) rd_sel_d = rd_sel_q + 1'b1;

    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus.in_valid && !in_ready_int && (count_q == FULL)) err_d = 1'b1;

    if (clear) begin
      stg_v_d  = '0;
      pf_v_d   = '0;
      wr_sel_d = '0;
      rd_sel_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        stg_data_d[b] = '0;
        pf_data_d[b]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_v_q  <= '0;
      pf_v_q   <= '0;
      wr_sel_q <= '0;
      rd_sel_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        stg_data_q[b] <= '0;
        pf_data_q[b]  <= '0;
      end
    end else begin
      stg_v_q    <= stg_v_d;
      pf_v_q     <= pf_v_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      count_q    <= count_d;
      err_q      <= err_d;
      stg_data_q <= stg_data_d;
      pf_data_q  <= pf_data_d;
    end
  end
endmodule

// File: tb/tb_interleaved_sync_fifo_nbank.sv
// Self-checking bench for interleaved_sync_fifo_nbank.
// Three instances (NUM_BANKS = 2, 4, 8; depth 16) share one stimulus; each
// has a queue-based reference model. Directed scenarios check instance 1
// (4 banks) against explicit values; the random scenario checks all three.
module tb_interleaved_sync_fifo_nbank;
  localparam int DEPTH = 16;
  localparam int N     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, clear, in_valid, out_ready;
  logic [7:0] in_data;

  logic       irdy [N], ovld [N], af [N], ae [N], er [N];
  logic [7:0] odat [N];
  logic [4:0] cnt  [N];

  interleaved_sync_fifo_nbank_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) if0 ();
  interleaved_sync_fifo_nbank_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) if1 ();
  interleaved_sync_fifo_nbank_if #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) if2 ();

  interleaved_sync_fifo_nbank #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .NUM_BANKS(2))
    u_dut0 (.clk(clk), .rstn(rstn), .clear(clear), .bus(if0));
  interleaved_sync_fifo_nbank #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .NUM_BANKS(4))
    u_dut1 (.clk(clk), .rstn(rstn), .clear(clear), .bus(if1));
  interleaved_sync_fifo_nbank #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .NUM_BANKS(8))
    u_dut2 (.clk(clk), .rstn(rstn), .clear(clear), .bus(if2));

  assign if0.in_data = in_data;  assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
  assign if1.in_data = in_data;  assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
  assign if2.in_data = in_data;  assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;

  assign irdy[0] = if0.in_ready;  assign ovld[0] = if0.out_valid;  assign odat[0] = if0.out_data;
  assign cnt[0]  = if0.count;     assign af[0]   = if0.almost_full; assign ae[0] = if0.almost_empty;
  assign er[0]   = if0.err;
  assign irdy[1] = if1.in_ready;  assign ovld[1] = if1.out_valid;  assign odat[1] = if1.out_data;
  assign cnt[1]  = if1.count;     assign af[1]   = if1.almost_full; assign ae[1] = if1.almost_empty;
  assign er[1]   = if1.err;
  assign irdy[2] = if2.in_ready;  assign ovld[2] = if2.out_valid;  assign odat[2] = if2.out_data;
  assign cnt[2]  = if2.count;     assign af[2]   = if2.almost_full; assign ae[2] = if2.almost_empty;
  assign er[2]   = if2.err;

  // Reference model: ordered list of held words plus sticky error bit.
  logic [7:0] mq [N][$];
  logic       m_err [N];

  // Per-cycle snapshot of DUT outputs and of model expectations.
  logic       s_irdy [N], s_ovld [N], s_af [N], s_ae [N], s_err [N];
  logic [7:0] s_odat [N];
  logic [4:0] s_cnt  [N];
  logic [4:0] e_cnt  [N];
  logic [7:0] e_head [N];
  logic       e_err  [N];
  logic       wacc [N], racc [N];

  int n_tests = 0;
  int n_fail  = 0;

  // One clock: sample at negedge, advance the model, step past posedge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rstn) begin
        mq[i].delete();
        m_err[i] = 1'b0;
      end
      s_irdy[i] = irdy[i];  s_ovld[i] = ovld[i];  s_odat[i] = odat[i];
      s_cnt[i]  = cnt[i];   s_af[i]   = af[i];    s_ae[i]   = ae[i];
      s_err[i]  = er[i];
      e_cnt[i]  = 5'(mq[i].size());
      e_head[i] = (mq[i].size() > 0) ? mq[i][0] : 8'h00;
      e_err[i]  = m_err[i];
      wacc[i]   = 1'b0;
      racc[i]   = 1'b0;
      if (rstn && !clear) begin
        wacc[i] = in_valid && irdy[i];
        racc[i] = ovld[i] && out_ready;
        if (in_valid && !irdy[i] && mq[i].size() == DEPTH) m_err[i] = 1'b1;
        if (racc[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (wacc[i]) mq[i].push_back(in_data);
      end
    end
    @(posedge clk);
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        m_err[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (3) cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cycle();
    for (int i = 0; i < N; i++) begin
      n_tests++; if (s_cnt[i] !== 5'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, s_cnt[i]); end
      n_tests++; if (s_irdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, s_irdy[i]); end
      n_tests++; if (s_ovld[i] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, s_ovld[i]); end
      n_tests++; if (s_odat[i] !== 8'h00) begin n_fail++; $display("FAIL reset_out_data[%0d]: got %h expected 00", i, s_odat[i]); end
      n_tests++; if (s_ae[i] !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty[%0d]: got %b expected 1", i, s_ae[i]); end
      n_tests++; if (s_af[i] !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full[%0d]: got %b expected 0", i, s_af[i]); end
      n_tests++; if (s_err[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", i, s_err[i]); end
    end
  endtask

  task automatic test_stream();
    int  wn = 0, rn = 0, lat = -1, acc_cyc = -1;
    bit  started = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 600 && rn < 200; k++) begin
      in_valid = (wn < 200);
      in_data  = 8'(wn);
      cycle();
      if (wacc[1] && acc_cyc < 0) acc_cyc = k;
      if (s_ovld[1] && !started) begin
        started = 1'b1;
        lat = k - acc_cyc;
      end else if (started) begin
        n_tests++; if (s_ovld[1] !== 1'b1) begin n_fail++; $display("FAIL stream_bubble: out_valid got %b expected 1 at read %0d", s_ovld[1], rn); end
      end
      if (racc[1]) begin
        n_tests++; if (s_odat[1] !== 8'(rn)) begin n_fail++; $display("FAIL stream_data: got %0d expected %0d", s_odat[1], rn); end
        rn++;
      end
      if (wacc[1]) wn++;
      for (int i = 0; i < N; i++) begin
        if (s_ovld[i]) begin
          n_tests++; if (e_cnt[i] == 5'd0 || s_odat[i] !== e_head[i]) begin n_fail++; $display("FAIL stream_model[%0d]: got %h expected %h (model count %0d)", i, s_odat[i], e_head[i], e_cnt[i]); end
        end
      end
    end
    n_tests++; if (rn != 200) begin n_fail++; $display("FAIL stream_reads: got %0d expected 200", rn); end
    n_tests++; if (lat < 1 || lat > 5) begin n_fail++; $display("FAIL stream_latency: got %0d expected 1..5", lat); end
    in_valid = 1'b0;
  endtask

  task automatic test_fill();
    bit acc;
    int rn = 0;
    do_reset();
    out_ready = 1'b0;
    for (int v = 0; v < 17; v++) begin
      in_valid = 1'b1;
      in_data  = 8'(v);
      acc = 1'b0;
      for (int k = 0; k < 8 && !acc; k++) begin
        cycle();
        acc = wacc[1];
        n_tests++; if (s_cnt[1] !== e_cnt[1]) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", s_cnt[1], e_cnt[1]); end
        n_tests++; if (s_af[1] !== (e_cnt[1] >= 5'd14)) begin n_fail++; $display("FAIL fill_almost_full: got %b at count %0d", s_af[1], e_cnt[1]); end
      end
      if (v < 16) begin
        n_tests++; if (!acc) begin n_fail++; $display("FAIL fill_accept: word %0d got refused expected accepted", v); end
      end else begin
        n_tests++; if (acc) begin n_fail++; $display("FAIL fill_17th_refused: got accepted expected refused"); end
      end
    end
    in_valid = 1'b0;
    cycle();
    n_tests++; if (s_cnt[1] !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", s_cnt[1]); end
    n_tests++; if (s_irdy[1] !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", s_irdy[1]); end
    n_tests++; if (s_af[1] !== 1'b1) begin n_fail++; $display("FAIL full_almost_full: got %b expected 1", s_af[1]); end
    n_tests++; if (s_err[1] !== 1'b1) begin n_fail++; $display("FAIL full_err: got %b expected 1", s_err[1]); end
    out_ready = 1'b1;
    for (int k = 0; k < 100 && rn < 16; k++) begin
      cycle();
      if (racc[1]) begin
        n_tests++; if (s_odat[1] !== 8'(rn)) begin n_fail++; $display("FAIL drain_data: got %0d expected %0d", s_odat[1], rn); end
        rn++;
      end
    end
    n_tests++; if (rn != 16) begin n_fail++; $display("FAIL drain_reads: got %0d expected 16", rn); end
    cycle();
    n_tests++; if (s_cnt[1] !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", s_cnt[1]); end
    n_tests++; if (s_ovld[1] !== 1'b0) begin n_fail++; $display("FAIL empty_out_valid: got %b expected 0", s_ovld[1]); end
    n_tests++; if (s_ae[1] !== 1'b1) begin n_fail++; $display("FAIL drain_almost_empty: got %b expected 1", s_ae[1]); end
    n_tests++; if (s_err[1] !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", s_err[1]); end
    out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int wn = 0;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 40 && wn < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(wn);
      cycle();
      if (wacc[1]) wn++;
    end
    in_valid = 1'b0;
    repeat (10) cycle();
    n_tests++; if (s_cnt[1] !== 5'd8) begin n_fail++; $display("FAIL sim_prefill: got %0d expected 8", s_cnt[1]); end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'h30 + 8'(wn);
      cycle();
      if (wacc[1]) wn++;
      n_tests++; if (s_cnt[1] !== 5'd8) begin n_fail++; $display("FAIL sim_count: got %0d expected 8 at cycle %0d", s_cnt[1], k); end
      n_tests++; if (!(wacc[1] && racc[1])) begin n_fail++; $display("FAIL sim_both_fire: got w=%b r=%b expected 1 1", wacc[1], racc[1]); end
      n_tests++; if (s_odat[1] !== 8'h30 + 8'(k)) begin n_fail++; $display("FAIL sim_data: got %h expected %h", s_odat[1], 8'h30 + 8'(k)); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    int wn = 0, n = 0;
    bit acc = 1'b0, got = 1'b0;
    do_reset();
    for (int k = 0; k < 40 && wn < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(wn);
      cycle();
      if (wacc[1]) wn++;
    end
    in_valid = 1'b0;
    repeat (6) cycle();
    n_tests++; if (s_cnt[1] !== 5'd7) begin n_fail++; $display("FAIL clear_prefill: got %0d expected 7", s_cnt[1]); end
    clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    cycle();
    n_tests++; if (s_irdy[1] !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b expected 0", s_irdy[1]); end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    n_tests++; if (s_cnt[1] !== 5'd0) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", s_cnt[1]); end
    n_tests++; if (s_ovld[1] !== 1'b0) begin n_fail++; $display("FAIL clear_out_valid: got %b expected 0", s_ovld[1]); end
    in_valid = 1'b1; in_data = 8'hA5;
    for (int k = 0; k < 10 && !acc; k++) begin
      cycle();
      acc = wacc[1];
    end
    n_tests++; if (!acc) begin n_fail++; $display("FAIL clear_write: A5 got refused expected accepted"); end
    in_valid = 1'b0; out_ready = 1'b1;
    while (n < 10 && !got) begin
      cycle();
      n++;
      got = racc[1];
    end
    n_tests++; if (!got || n > 5) begin n_fail++; $display("FAIL clear_latency: got read=%b after %0d cycles expected within 5", got, n); end
    n_tests++; if (s_odat[1] !== 8'hA5) begin n_fail++; $display("FAIL clear_first_read: got %h expected a5", s_odat[1]); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int pin, pout;
    int reads [N];
    do_reset();
    for (int i = 0; i < N; i++) reads[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 250) % 4)
        0:       begin pin = 90;  pout = 25;  end
        1:       begin pin = 25;  pout = 90;  end
        2:       begin pin = 50;  pout = 50;  end
        default: begin pin = 100; pout = 100; end
      endcase
      in_valid  = ($urandom_range(99) < pin);
      out_ready = ($urandom_range(99) < pout);
      in_data   = 8'($urandom);
      clear     = ($urandom_range(299) == 0);
      if (cyc == 1502) rstn = 1'b1;
      if (cyc == 1500) begin
        #2;
        rstn = 1'b0;
      end
      cycle();
      for (int i = 0; i < N; i++) begin
        if (racc[i]) reads[i]++;
        n_tests++; if (s_cnt[i] !== e_cnt[i]) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d cycle %0d", i, s_cnt[i], e_cnt[i], cyc); end
        n_tests++; if (s_err[i] !== e_err[i]) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b cycle %0d", i, s_err[i], e_err[i], cyc); end
        n_tests++; if (s_af[i] !== (e_cnt[i] >= 5'd14)) begin n_fail++; $display("FAIL rand_almost_full[%0d]: got %b count %0d", i, s_af[i], e_cnt[i]); end
        n_tests++; if (s_ae[i] !== (e_cnt[i] <= 5'd1)) begin n_fail++; $display("FAIL rand_almost_empty[%0d]: got %b count %0d", i, s_ae[i], e_cnt[i]); end
        if (e_cnt[i] == 5'd16) begin
          n_tests++; if (s_irdy[i] !== 1'b0) begin n_fail++; $display("FAIL rand_full_in_ready[%0d]: got %b expected 0", i, s_irdy[i]); end
        end
        if (s_ovld[i]) begin
          n_tests++; if (e_cnt[i] == 5'd0 || s_odat[i] !== e_head[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h (model count %0d) cycle %0d", i, s_odat[i], e_head[i], e_cnt[i], cyc); end
        end
      end
    end
    clear = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_tests++; if (reads[i] < 300) begin n_fail++; $display("FAIL rand_progress[%0d]: got %0d reads expected at least 300", i, reads[i]); end
    end
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    for (int i = 0; i < N; i++) m_err[i] = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_simultaneous();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
